// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - instruction ROM, data memory and ALU bus of the accumulator sequencer
interface alu_sequencer_if #(
    parameter int PC_W = 8
);
    logic            INSTR_REQ;
    logic [PC_W-1:0] INSTR_ADDR;
    logic            INSTR_ACK;
    logic [8:0]      INSTR_DATA;

    logic            MEM_REQ;
    logic            MEM_WE;
    logic [7:0]      MEM_ADDR;
    logic [7:0]      MEM_WDATA;
    logic            MEM_ACK;
    logic [7:0]      MEM_RDATA;

    logic [3:0]      ALU_OP;
    logic            ALU_FLAG;
    logic [4:0]      ALU_IMME;
    logic [7:0]      ALU_INA;
    logic [7:0]      ALU_INB;
    logic [7:0]      ALU_OUT;
    logic            ALU_CARRY;
    logic            ALU_ISZERO;

    modport master (
        output INSTR_REQ, INSTR_ADDR,
        input  INSTR_ACK, INSTR_DATA,
        output MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
        input  MEM_ACK, MEM_RDATA,
        output ALU_OP, ALU_FLAG, ALU_IMME, ALU_INA, ALU_INB,
        input  ALU_OUT, ALU_CARRY, ALU_ISZERO
    );

    modport slave (
        input  INSTR_REQ, INSTR_ADDR,
        output INSTR_ACK, INSTR_DATA,
        input  MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA,
        output MEM_ACK, MEM_RDATA,
        input  ALU_OP, ALU_FLAG, ALU_IMME, ALU_INA, ALU_INB,
        output ALU_OUT, ALU_CARRY, ALU_ISZERO
    );
endinterface

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - multi-cycle fetch/operand/execute control FSM for the 8-bit accumulator ALU
// Optional ILLEGAL_OP_TRAP_EN: undefined opcodes halt with ILLEGAL=1 instead of executing as NOPs.
module alu_sequencer #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   START,
    alu_sequencer_if.master        bus,
    output logic [7:0]             ACC,
    output logic                   CARRY,
    output logic                   HALTED
`ifdef ILLEGAL_OP_TRAP_EN
    ,
    output logic                   ILLEGAL
`endif
);

    localparam logic [3:0] kMOVE  = 4'h0;
    localparam logic [3:0] kADDI  = 4'h1;
    localparam logic [3:0] kADDR  = 4'h2;
    localparam logic [3:0] kSUBR  = 4'h3;
    localparam logic [3:0] kSL    = 4'h4;
    localparam logic [3:0] kSLR   = 4'h5;
    localparam logic [3:0] kSNE   = 4'h6;
    localparam logic [3:0] kSEQ   = 4'h7;
    localparam logic [3:0] kSLT   = 4'h8;
    localparam logic [3:0] kLOAD  = 4'h9;
    localparam logic [3:0] kOR    = 4'hA;
    localparam logic [3:0] kSTORE = 4'hB;
    localparam logic [3:0] kBEO   = 4'hC;
    localparam logic [3:0] kBEZ   = 4'hD;

    localparam logic [8:0]      HALT_WORD = 9'h1FF;
    localparam logic [PC_W-1:0] PC_ONE    = 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_OPERAND,
        S_EXEC,
        S_STORE,
        S_HALT
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [8:0]      ir;
    logic [7:0]      opnd;
    logic            instr_req;
    logic            mem_req;
    logic            mem_we;

    logic [3:0]      op;
    logic [PC_W-1:0] branch_off;
    logic            needs_operand;
    logic            writes_acc;
    logic            writes_carry;
    logic            is_branch;

    assign op            = ir[8:5];
    assign branch_off    = {{(PC_W-5){ir[4]}}, ir[4:0]};
    assign needs_operand = op inside {kADDR, kSUBR, kSLR, kSNE, kSEQ, kSLT, kLOAD, kOR};
    assign writes_acc    = op inside {kMOVE, kADDI, kADDR, kSUBR, kSL, kSLR, kSNE, kSEQ, kSLT, kLOAD, kOR};
    assign writes_carry  = op inside {kADDI, kADDR, kSUBR, kSL, kSLR};
    assign is_branch     = (op == kBEO) || (op == kBEZ);

    assign bus.INSTR_REQ  = instr_req;
    assign bus.INSTR_ADDR = pc;
    assign bus.MEM_REQ    = mem_req;
    assign bus.MEM_WE     = mem_we;
    assign bus.MEM_ADDR   = {3'b000, ir[4:0]};
    assign bus.MEM_WDATA  = ACC;
    assign bus.ALU_OP     = ir[8:5];
    assign bus.ALU_FLAG   = ir[4];
    assign bus.ALU_IMME   = ir[4:0];
    assign bus.ALU_INA    = ACC;
    assign bus.ALU_INB    = opnd;

`ifdef ILLEGAL_OP_TRAP_EN
    logic illegal;
    logic is_defined;
    assign is_defined = (op <= kBEZ);
    assign ILLEGAL    = illegal;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= S_IDLE;
            pc        <= RESET_PC;
            ir        <= '0;
            opnd      <= '0;
            ACC       <= '0;
            CARRY     <= 1'b0;
            HALTED    <= 1'b0;
            instr_req <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
            illegal   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (START) begin
                        state     <= S_FETCH;
                        pc        <= RESET_PC;
                        instr_req <= 1'b1;
                        HALTED    <= 1'b0;
`ifdef ILLEGAL_OP_TRAP_EN
                        illegal   <= 1'b0;
`endif
                    end
                end
                S_FETCH: begin
                    if (bus.INSTR_ACK) begin
                        ir        <= bus.INSTR_DATA;
                        instr_req <= 1'b0;
                        state     <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    // The all-ones word halts even though its opcode field is undefined.
                    if (ir == HALT_WORD) begin
                        state  <= S_HALT;
                        HALTED <= 1'b1;
`ifdef ILLEGAL_OP_TRAP_EN
                    end else if (!is_defined) begin
                        state   <= S_HALT;
                        HALTED  <= 1'b1;
                        illegal <= 1'b1;
`endif
                    end else if (needs_operand) begin
                        state   <= S_OPERAND;
                        mem_req <= 1'b1;
                        mem_we  <= 1'b0;
                    end else if (op == kSTORE) begin
                        state   <= S_STORE;
                        mem_req <= 1'b1;
                        mem_we  <= 1'b1;
                    end else begin
                        state <= S_EXEC;
                    end
                end
                S_OPERAND: begin
                    if (bus.MEM_ACK) begin
                        opnd    <= bus.MEM_RDATA;
                        mem_req <= 1'b0;
                        state   <= S_EXEC;
                    end
                end
                S_STORE: begin
                    if (bus.MEM_ACK) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        pc        <= pc + PC_ONE;
                        instr_req <= 1'b1;
                        state     <= S_FETCH;
                    end
                end
                S_EXEC: begin
                    if (writes_acc) ACC <= bus.ALU_OUT;
                    if (writes_carry) CARRY <= bus.ALU_CARRY;
                    if (is_branch && bus.ALU_ISZERO) pc <= pc + branch_off;
                    else pc <= pc + PC_ONE;
                    instr_req <= 1'b1;
                    state     <= S_FETCH;
                end
                default: begin
                    state     <= S_IDLE;
                    instr_req <= 1'b0;
                    mem_req   <= 1'b0;
                    mem_we    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer against an instruction-level model
module tb_alu_sequencer;

    localparam logic [3:0] kMOVE  = 4'h0;
    localparam logic [3:0] kADDI  = 4'h1;
    localparam logic [3:0] kADDR  = 4'h2;
    localparam logic [3:0] kSUBR  = 4'h3;
    localparam logic [3:0] kSL    = 4'h4;
    localparam logic [3:0] kSLR   = 4'h5;
    localparam logic [3:0] kSNE   = 4'h6;
    localparam logic [3:0] kSEQ   = 4'h7;
    localparam logic [3:0] kSLT   = 4'h8;
    localparam logic [3:0] kLOAD  = 4'h9;
    localparam logic [3:0] kOR    = 4'hA;
    localparam logic [3:0] kSTORE = 4'hB;
    localparam logic [3:0] kBEO   = 4'hC;
    localparam logic [3:0] kBEZ   = 4'hD;
    localparam logic [8:0] HALT_W = 9'h1FF;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       START = 1'b0;
    logic [7:0] ACC;
    logic       CARRY;
    logic       HALTED;
`ifdef ILLEGAL_OP_TRAP_EN
    logic       ILLEGAL;
`endif

    alu_sequencer_if #(.PC_W(8)) bus ();

    alu_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .START  (START),
        .bus    (bus.master),
        .ACC    (ACC),
        .CARRY  (CARRY),
        .HALTED (HALTED)
`ifdef ILLEGAL_OP_TRAP_EN
        ,
        .ILLEGAL(ILLEGAL)
`endif
    );

    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [8:0] rom       [0:255];
    logic [7:0] env_mem   [0:31];
    logic [7:0] model_mem [0:31];

    logic [7:0] m_pc, m_acc, m_opnd;
    logic       m_carry, m_halted, m_illegal;
    logic [7:0] exp_addr, exp_wdata;
    logic       exp_we;
    int         store_cycles = 0;
    int         run_cycles = 0;
    int         m_delay_cfg = 0;
    bit         rand_delay = 0;

    function automatic logic [9:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                         input logic [4:0] imm, input logic flag);
        logic [8:0] s;
        logic       z;
        s = 9'h0;
        z = 1'b0;
        case (op)
            kMOVE:   s = {4'h0, imm};
            kADDI:   s = {1'b0, a} + {4'h0, imm};
            kADDR:   s = {1'b0, a} + {1'b0, b};
            kSUBR:   s = {1'b0, a} - {1'b0, b};
            kSL:     s = flag ? {a[0], 1'b0, a[7:1]} : {a, 1'b0};
            kSLR:    s = {1'b0, a} << b[2:0];
            kSNE:    s = {8'h0, a != b};
            kSEQ:    s = {8'h0, a == b};
            kSLT:    s = {8'h0, a < b};
            kLOAD:   s = {1'b0, b};
            kOR:     s = {1'b0, a | b};
            kBEO:    z = a[0];
            kBEZ:    z = (a == 8'h00);
            default: s = 9'h0;
        endcase
        return {z, s};
    endfunction

    logic [9:0] alu_r;
    always_comb alu_r = alu_f(bus.ALU_OP, bus.ALU_INA, bus.ALU_INB, bus.ALU_IMME, bus.ALU_FLAG);
    assign bus.ALU_OUT    = alu_r[7:0];
    assign bus.ALU_CARRY  = alu_r[8];
    assign bus.ALU_ISZERO = alu_r[9];

    initial begin : responder
        int  i_cnt, m_cnt;
        bit  i_busy, m_busy;
        i_cnt = 0; m_cnt = 0; i_busy = 0; m_busy = 0;
        bus.INSTR_ACK = 1'b0; bus.INSTR_DATA = 9'h0;
        bus.MEM_ACK = 1'b0; bus.MEM_RDATA = 8'h0;
        forever begin
            @(posedge CLK);
            #2;
            bus.INSTR_ACK = 1'b0;
            bus.MEM_ACK   = 1'b0;
            if (!RST_N) begin
                i_busy = 0;
                m_busy = 0;
            end else begin
                if (bus.INSTR_REQ === 1'b1) begin
                    if (!i_busy) begin
                        i_cnt  = rand_delay ? int'($urandom_range(2, 0)) : 0;
                        i_busy = 1;
                    end
                    if (i_cnt == 0) begin
                        bus.INSTR_ACK  = 1'b1;
                        bus.INSTR_DATA = rom[bus.INSTR_ADDR];
                        i_busy = 0;
                    end else i_cnt--;
                end
                if (bus.MEM_REQ === 1'b1) begin
                    if (!m_busy) begin
                        m_cnt  = rand_delay ? int'($urandom_range(2, 0)) : m_delay_cfg;
                        m_busy = 1;
                    end
                    if (m_cnt == 0) begin
                        bus.MEM_ACK = 1'b1;
                        if (bus.MEM_WE) env_mem[bus.MEM_ADDR[4:0]] = bus.MEM_WDATA;
                        else bus.MEM_RDATA = env_mem[bus.MEM_ADDR[4:0]];
                        m_busy = 0;
                    end else m_cnt--;
                end
            end
        end
    end

    initial begin : mem_monitor
        forever begin
            @(negedge CLK);
            if (RST_N && bus.MEM_REQ === 1'b1) begin
                check("mem_addr", bus.MEM_ADDR, exp_addr);
                check("mem_we", bus.MEM_WE, exp_we);
                if (exp_we) begin
                    check("mem_wdata", bus.MEM_WDATA, exp_wdata);
                    store_cycles++;
                end
            end
        end
    end

    task automatic model_reset();
        m_pc = 8'h00; m_acc = 8'h00; m_opnd = 8'h00;
        m_carry = 1'b0; m_halted = 1'b0; m_illegal = 1'b0;
    endtask

    task automatic model_start();
        m_pc = 8'h00; m_halted = 1'b0; m_illegal = 1'b0;
    endtask

    task automatic model_step(input logic [8:0] instr);
        logic [3:0] op;
        logic [4:0] imm;
        logic [9:0] r;
        op  = instr[8:5];
        imm = instr[4:0];
        if (instr == HALT_W) begin
            m_halted = 1'b1;
            return;
        end
        exp_addr = {3'b000, imm};
        exp_we   = (op == kSTORE);
        if (op == kSTORE) begin
            exp_wdata = m_acc;
            model_mem[imm] = m_acc;
            m_pc = m_pc + 8'd1;
            return;
        end
        if (op > kBEZ) begin
`ifdef ILLEGAL_OP_TRAP_EN
            m_halted = 1'b1;
            m_illegal = 1'b1;
`else
            m_pc = m_pc + 8'd1;
`endif
            return;
        end
        if (op inside {kADDR, kSUBR, kSLR, kSNE, kSEQ, kSLT, kLOAD, kOR}) m_opnd = model_mem[imm];
        r = alu_f(op, m_acc, m_opnd, imm, imm[4]);
        if (op inside {kMOVE, kADDI, kADDR, kSUBR, kSL, kSLR, kSNE, kSEQ, kSLT, kLOAD, kOR}) m_acc = r[7:0];
        if (op inside {kADDI, kADDR, kSUBR, kSL, kSLR}) m_carry = r[8];
        if ((op == kBEO || op == kBEZ) && r[9]) m_pc = m_pc + {{3{imm[4]}}, imm};
        else m_pc = m_pc + 8'd1;
    endtask

    function automatic logic [8:0] enc(input logic [3:0] op, input logic [4:0] imm);
        return {op, imm};
    endfunction

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = HALT_W;
    endtask

    task automatic set_mem(input int a, input logic [7:0] v);
        env_mem[a] = v;
        model_mem[a] = v;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST_N = 1'b0;
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        model_reset();
    endtask

    task automatic pulse_start();
        @(negedge CLK);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic run_program(input int max_steps);
        int steps, guard;
        bit timed_out;
        pulse_start();
        model_start();
        steps = 0; guard = 0; timed_out = 1; run_cycles = 0;
        while (guard < 3000) begin
            if (HALTED === 1'b1) begin timed_out = 0; break; end
            if (steps >= max_steps && !m_halted) begin timed_out = 0; break; end
            if (bus.INSTR_REQ === 1'b1 && bus.INSTR_ACK === 1'b1) begin
                check("extra_fetch", m_halted, 1'b0);
                check("fetch_pc", bus.INSTR_ADDR, m_pc);
                check("fetch_acc", ACC, m_acc);
                check("fetch_carry", CARRY, m_carry);
                if (!m_halted) begin
                    model_step(rom[m_pc]);
                    steps++;
                end
            end
            @(negedge CLK);
            run_cycles++;
            guard++;
        end
        check("run_bound", timed_out, 1'b0);
        check("halted", HALTED, m_halted);
        if (m_halted) begin
            check("end_acc", ACC, m_acc);
            check("end_carry", CARRY, m_carry);
            check("end_pc", bus.INSTR_ADDR, m_pc);
`ifdef ILLEGAL_OP_TRAP_EN
            check("end_illegal", ILLEGAL, m_illegal);
`endif
        end
    endtask

    initial begin : main
        int guard;
        clear_rom();
        for (int i = 0; i < 32; i++) set_mem(i, 8'h00);
        model_reset();
        exp_addr = 8'h00; exp_we = 1'b0; exp_wdata = 8'h00;
        repeat (2) @(negedge CLK);
        check("rst_instr_req", bus.INSTR_REQ, 1'b0);
        check("rst_mem_req", bus.MEM_REQ, 1'b0);
        check("rst_mem_we", bus.MEM_WE, 1'b0);
        check("rst_acc", ACC, 8'h00);
        check("rst_halted", HALTED, 1'b0);
        RST_N = 1'b1;

        rom[0] = enc(kMOVE, 5'd5);
        rom[1] = enc(kADDI, 5'd3);
        run_program(10);
        check("t1_cycles", run_cycles, 8);
        check("t1_acc", ACC, 8'h08);
        check("t1_carry", CARRY, 1'b0);
        check("t1_pc", bus.INSTR_ADDR, 8'h02);
        check("t1_halted", HALTED, 1'b1);

        clear_rom();
        rom[0] = enc(kADDI, 5'd1);
        run_program(10);
        check("restart_acc_kept", ACC, 8'h09);

        do_reset();
        clear_rom();
        set_mem(1, 8'hF0);
        set_mem(4, 8'h20);
        rom[0] = enc(kLOAD, 5'd1);
        rom[1] = enc(kADDR, 5'd4);
        run_program(10);
        check("addr_acc", ACC, 8'h10);
        check("addr_carry", CARRY, 1'b1);

        do_reset();
        clear_rom();
        rom[0] = enc(kMOVE, 5'd0);
        rom[1] = enc(kBEZ, 5'h1E);
        run_program(10);
        check("bez_taken_pc", bus.INSTR_ADDR, 8'hFF);

        do_reset();
        clear_rom();
        rom[0] = enc(kMOVE, 5'd3);
        rom[1] = enc(kBEZ, 5'h1E);
        run_program(10);
        check("bez_not_taken_pc", bus.INSTR_ADDR, 8'h02);

        do_reset();
        clear_rom();
        set_mem(3, 8'hA5);
        rom[0] = enc(kLOAD, 5'd3);
        rom[1] = enc(kSTORE, 5'd7);
        m_delay_cfg = 3;
        store_cycles = 0;
        run_program(10);
        m_delay_cfg = 0;
        check("store_hold_cycles", store_cycles, 4);
        check("store_mem", env_mem[7], 8'hA5);
        check("store_acc", ACC, 8'hA5);

        do_reset();
        clear_rom();
        rom[0] = enc(kMOVE, 5'd7);
        rom[1] = enc(4'hE, 5'd3);
        rom[2] = enc(kMOVE, 5'd4);
        run_program(10);
`ifdef ILLEGAL_OP_TRAP_EN
        check("undef_pc", bus.INSTR_ADDR, 8'h01);
        check("undef_acc", ACC, 8'h07);
        check("undef_illegal", ILLEGAL, 1'b1);
        pulse_start();
        check("start_clears_illegal", ILLEGAL, 1'b0);
        check("start_clears_halted", HALTED, 1'b0);
`else
        check("undef_pc", bus.INSTR_ADDR, 8'h03);
        check("undef_acc", ACC, 8'h04);
`endif

        do_reset();
        clear_rom();
        set_mem(1, 8'h33);
        rom[0] = enc(kMOVE, 5'd9);
        rom[1] = enc(kLOAD, 5'd1);
        exp_addr = 8'h01; exp_we = 1'b0;
        m_delay_cfg = 10;
        pulse_start();
        guard = 0;
        while (bus.MEM_REQ !== 1'b1 && guard < 20) begin
            @(negedge CLK);
            guard++;
        end
        check("opnd_wait_bound", guard < 20, 1'b1);
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        @(negedge CLK);
        check("start_ignored_req", bus.MEM_REQ, 1'b1);
        check("start_ignored_pc", bus.INSTR_ADDR, 8'h01);
        check("pre_rst_acc", ACC, 8'h09);
        @(posedge CLK);
        #1;
        RST_N = 1'b0;
        #1;
        check("async_rst_mem_req", bus.MEM_REQ, 1'b0);
        check("async_rst_acc", ACC, 8'h00);
        check("async_rst_pc", bus.INSTR_ADDR, 8'h00);
        check("async_rst_halted", HALTED, 1'b0);
        repeat (2) @(negedge CLK);
        RST_N = 1'b1;
        model_reset();
        m_delay_cfg = 0;

        rand_delay = 1;
        for (int t = 0; t < 8; t++) begin
            do_reset();
            for (int i = 0; i < 256; i++) rom[i] = 9'($urandom_range(511, 0));
            for (int i = 0; i < 32; i++) set_mem(i, 8'($urandom_range(255, 0)));
            run_program(40);
        end
        rand_delay = 0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
